// File: rtl/matmul_pkg.sv
// Shared constants and state type for the 3x3 fp8 matrix-multiplier streaming port.
// Elements are opaque fp8 bytes: sign, 3-bit exponent, 4-bit fraction.
package matmul_pkg;
  localparam int EW       = 8;
  localparam int MAT_N    = 3;
  localparam int NEL      = MAT_N * MAT_N;
  localparam int NOPS     = 2 * NEL;
  localparam int LATENCY  = 9;

  localparam int SIGN_BIT = 7;
  localparam int EXP_MSB  = 6;
  localparam int EXP_LSB  = 4;
  localparam int FRAC_MSB = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    DRAIN   = 3'd5
  } state_t;
endpackage

// File: rtl/matmul_stream_ctrl.sv
// Batch sequencer: operand load, array start, fixed-latency wait, result capture and drain.
// Holds the load, wait and drain counters; every handshake output is decoded from the state.
module matmul_stream_ctrl
  import matmul_pkg::*;
#(
  parameter int LATENCY = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic       m_ready,
  output logic [4:0] ld_cnt,
  output logic [3:0] dr_cnt,
  output logic       load_we,
  output logic       capture_en,
  output logic       s_ready,
  output logic       m_valid,
  output logic       m_last,
  output logic       mm_start,
  output logic       busy
);
  localparam logic [4:0] LD_LAST = 5'(NOPS - 1);
  localparam logic [3:0] WT_LAST = 4'(LATENCY - 1);
  localparam logic [3:0] DR_LAST = 4'(NEL - 1);

  state_t     state_q, state_d;
  logic [4:0] ld_q, ld_d;
  logic [3:0] wt_q, wt_d;
  logic [3:0] dr_q, dr_d;
  logic       mm_start_q, mm_start_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_q       <= '0;
      wt_q       <= '0;
      dr_q       <= '0;
      mm_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      wt_q       <= wt_d;
      dr_q       <= dr_d;
      mm_start_q <= mm_start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    wt_d    = wt_q;
    dr_d    = dr_q;
    case (state_q)
      IDLE: begin
        ld_d    = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (s_valid) begin
          ld_d = ld_q + 5'd1;
          if (ld_q == LD_LAST) state_d = START;
        end
      end
      START: begin
        wt_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wt_d = wt_q + 4'd1;
        if (wt_q == WT_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        dr_d    = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (m_ready) begin
          dr_d = dr_q + 4'd1;
          if (dr_q == DR_LAST) begin
            ld_d    = '0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so the array sees a clean pulse aligned with the START state.
    mm_start_d = (state_d == START);
  end

  assign s_ready    = (state_q == LOAD);
  assign m_valid    = (state_q == DRAIN);
  assign m_last     = m_valid && (dr_q == DR_LAST);
  assign busy       = (state_q == START) || (state_q == WAIT) ||
                      (state_q == CAPTURE) || (state_q == DRAIN);
  assign load_we    = s_ready && s_valid;
  assign capture_en = (state_q == CAPTURE);
  assign mm_start   = mm_start_q;
  assign ld_cnt     = ld_q;
  assign dr_cnt     = dr_q;
endmodule

// File: rtl/matmul_stream_port.sv
// Host streaming port for the 3x3 fp8 systolic array: byte stream in to parallel A/B,
// parallel C captured after the array latency and streamed back out row-major.
module matmul_stream_port
  import matmul_pkg::*;
#(
  parameter int LATENCY = matmul_pkg::LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [EW-1:0]     s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [EW-1:0]     m_data,
  output logic              m_last,
  output logic              mm_start,
  output logic [NEL*EW-1:0] a_flat,
  output logic [NEL*EW-1:0] b_flat,
  input  logic [NEL*EW-1:0] c_flat,
  output logic              busy
);
  localparam logic [4:0] OP_N = 5'(NOPS);
  localparam logic [3:0] EL_N = 4'(NEL);

  logic [4:0] ld_cnt;
  logic [3:0] dr_cnt;
  logic       load_we;
  logic       capture_en;

  matmul_stream_ctrl #(.LATENCY(LATENCY)) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .m_ready    (m_ready),
    .ld_cnt     (ld_cnt),
    .dr_cnt     (dr_cnt),
    .load_we    (load_we),
    .capture_en (capture_en),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .mm_start   (mm_start),
    .busy       (busy)
  );

  // Operand file: entries 0..8 are A, 9..17 are B, both row-major.
  logic [EW-1:0]     op_q [NOPS];
  logic [EW-1:0]     op_d [NOPS];
  logic [NEL*EW-1:0] c_q, c_d;
  logic [EW-1:0]     c_el [NEL];

  always_comb begin
    op_d = op_q;
    if (load_we && (ld_cnt < OP_N)) op_d[ld_cnt] = s_data;
    c_d = capture_en ? c_flat : c_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NOPS; i++) op_q[i] <= '0;
      c_q <= '0;
    end else begin
      op_q <= op_d;
      c_q  <= c_d;
    end
  end

  for (genvar gi = 0; gi < NEL; gi++) begin : g_pack
    assign a_flat[(NEL-1-gi)*EW +: EW] = op_q[gi];
    assign b_flat[(NEL-1-gi)*EW +: EW] = op_q[NEL+gi];
    assign c_el[gi]                    = c_q[(NEL-1-gi)*EW +: EW];
  end

  always_comb begin
    m_data = '0;
    if (dr_cnt < EL_N) m_data = c_el[dr_cnt];
  end
endmodule

// File: tb/tb_matmul_stream_port.sv
// Self-checking bench for matmul_stream_port: directed vector table, randomized batches
// against a byte-level model, stray traffic, backpressure and reset mid-WAIT.
module tb_matmul_stream_port;
  localparam int LAT = 9;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        mm_start;
  logic [71:0] a_flat;
  logic [71:0] b_flat;
  logic [71:0] c_flat;
  logic        busy;

  matmul_stream_port #(.LATENCY(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .mm_start (mm_start),
    .a_flat   (a_flat),
    .b_flat   (b_flat),
    .c_flat   (c_flat),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  cur_ops [18];
  logic [71:0] stub_val;
  int          stub_cnt;

  function automatic logic [71:0] rand72();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[71:0];
  endfunction

  // Array stub: garbage until LATENCY cycles after mm_start, then the result; scrambled during drain.
  always @(posedge clk) begin
    if (!rst_n) begin
      stub_cnt <= 0;
      c_flat   <= '0;
    end else if (mm_start) begin
      stub_cnt <= LAT;
      c_flat   <= rand72();
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) c_flat <= stub_val;
    end else if (m_valid) begin
      c_flat <= rand72();
    end
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: a matrix is the row-major concatenation of its nine bytes.
  function automatic logic [71:0] pack9(input int base);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v = {v[63:0], cur_ops[base+i]};
    return v;
  endfunction

  function automatic logic [7:0] elem_of(input logic [71:0] m, input int k);
    logic [71:0] t;
    t = m >> (8 * (8 - k));
    return t[7:0];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_flat"}, a_flat, 72'h0);
    chk({tag, "_b_flat"}, b_flat, 72'h0);
    chk({tag, "_m_data"}, 72'(m_data), 72'h0);
    chk({tag, "_ctrl"}, 72'({s_ready, m_valid, m_last, mm_start, busy}), 72'h0);
  endtask

  task automatic load_ops(input int gap_mode);
    int   idx;
    int   cyc;
    int   early;
    logic v;
    logic rdy;
    idx = 0; cyc = 0; early = 0;
    while (idx < 18 && cyc < 400) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      rdy     = s_ready;
      s_valid = v;
      s_data  = v ? cur_ops[idx] : 8'($urandom());
      if (mm_start) early++;
      @(posedge clk); #1;
      if (v && rdy) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    chki("load_handshakes", idx, 18);
    chki("mm_start_early", early, 0);
    chk("mm_start_after_last", 72'(mm_start), 72'h1);
  endtask

  task automatic run_batch(input int tag, input int gap_mode, input int rdy_mode,
                           input logic [71:0] exp_a, input logic [71:0] exp_b,
                           input logic [71:0] exp_c, input int exp_drain);
    int   lat;
    int   bad;
    int   k;
    int   cyc;
    logic r;
    stub_val = exp_c;
    load_ops(gap_mode);
    chk("a_flat", a_flat, exp_a);
    chk("b_flat", b_flat, exp_b);
    lat = 0; bad = 0;
    while (!m_valid && lat < 100) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom());
      if (s_ready || !busy) bad++;
      @(posedge clk); #1;
      lat++;
      if (mm_start) bad++;
    end
    chki("result_latency", lat, 11);
    chki("wait_stray_or_busy", bad, 0);
    k = 0; cyc = 0; bad = 0;
    while (k < 9 && cyc < 200) begin
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = ($urandom_range(0, 2) != 0);
      endcase
      m_ready = r;
      s_valid = 1'b1;
      s_data  = 8'($urandom());
      if (s_ready || !m_valid) bad++;
      chk("m_data", 72'(m_data), 72'(elem_of(exp_c, k)));
      chk("m_last", 72'(m_last), 72'(k == 8));
      @(posedge clk); #1;
      if (r) k++;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chki("drain_bytes", k, 9);
    chki("drain_stray_or_valid", bad, 0);
    if (exp_drain > 0) chki("drain_cycles", cyc, exp_drain);
    chk("a_flat_held", a_flat, exp_a);
    chk("b_flat_held", b_flat, exp_b);
    chk("after_drain_m_valid_busy", 72'({m_valid, busy}), 72'h0);
    chk("after_drain_s_ready", 72'(s_ready), 72'h1);
    $display("batch %0d a=%h b=%h c=%h latency=%0d drain_cycles=%0d", tag, a_flat, b_flat, exp_c, lat, cyc);
  endtask

  typedef struct {
    logic [7:0]  base;
    int          gap_mode;
    int          rdy_mode;
    logic [71:0] c;
    logic [71:0] exp_a;
    logic [71:0] exp_b;
    int          exp_drain;
  } vec_t;

  vec_t vecs [3];

  initial begin
    vecs[0] = '{8'h01, 0, 0, 72'h112233445566778899, 72'h010203040506070809, 72'h0A0B0C0D0E0F101112, 9};
    vecs[1] = '{8'h21, 0, 1, 72'h99AABBCCDDEEFF0011, 72'h212223242526272829, 72'h2A2B2C2D2E2F303132, 17};
    vecs[2] = '{8'h40, 1, 0, 72'h0F1E2D3C4B5A697887, 72'h404142434445464748, 72'h494A4B4C4D4E4F5051, 9};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; stub_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 18; i++) cur_ops[i] = vecs[v].base + 8'(i);
      run_batch(v, vecs[v].gap_mode, vecs[v].rdy_mode, vecs[v].exp_a, vecs[v].exp_b,
                vecs[v].c, vecs[v].exp_drain);
    end

    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 18; i++) cur_ops[i] = 8'($urandom());
      run_batch(10 + b, 2, 2, pack9(0), pack9(9), rand72(), -1);
    end

    // Reset while the array is computing, then a clean batch from scratch.
    for (int i = 0; i < 18; i++) cur_ops[i] = 8'($urandom());
    stub_val = rand72();
    load_ops(0);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_busy", 72'(busy), 72'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all_zero("midwait_reset");
    for (int i = 0; i < 18; i++) cur_ops[i] = 8'($urandom());
    run_batch(20, 0, 0, pack9(0), pack9(9), rand72(), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
